// File: rtl/pc_sequencer_pkg.sv
// Shared types for the PC sequencer: branch kinds, compare selects
// and the branch FSM state encoding.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        BK_BR   = 2'd0,
        BK_JAL  = 2'd1,
        BK_JALR = 2'd2,
        BK_ILL  = 2'd3
    } br_kind_e;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EVAL    = 2'd1,
        RESOLVE = 2'd2
    } br_state_e;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch, instruction-buffer and branch handshake bundle between the
// PC sequencer (master) and imem/decode (slave).
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic        fetch_req_valid;
    logic        fetch_req_ready;
    logic [31:0] fetch_addr;
    logic        fetch_rsp_valid;
    logic [31:0] fetch_rsp_data;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    logic        br_valid;
    logic        br_ready;
    br_kind_e    br_kind;
    logic [2:0]  br_funct3;
    logic [31:0] br_rs1;
    logic [31:0] br_rs2;
    logic [31:0] br_pc;
    logic [31:0] br_offset;
    logic        br_done;
    logic [31:0] br_link;
    logic        br_misalign;
    logic        br_illegal;
    logic        flush;

    modport master (
        output fetch_req_valid, fetch_addr,
        input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready,
        input  br_valid, br_kind, br_funct3, br_rs1, br_rs2,
        input  br_pc, br_offset,
        output br_ready, br_done, br_link, br_misalign, br_illegal,
        output flush
    );

    modport slave (
        input  fetch_req_valid, fetch_addr,
        output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready,
        output br_valid, br_kind, br_funct3, br_rs1, br_rs2,
        output br_pc, br_offset,
        input  br_ready, br_done, br_link, br_misalign, br_illegal,
        input  flush
    );

endinterface

// File: rtl/pc_sequencer_branch_compare.sv
// Combinational branch condition evaluation for conditional branches.
module branch_compare
    import pc_sequencer_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        taken_o,
    output logic        illegal_o
);

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        unique case (funct3_i)
            FUNCT3_BEQ:  taken_o = (rs1_i == rs2_i);
            FUNCT3_BNE:  taken_o = (rs1_i != rs2_i);
            FUNCT3_BLT:  taken_o = ($signed(rs1_i) < $signed(rs2_i));
            FUNCT3_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
            FUNCT3_BLTU: taken_o = (rs1_i < rs2_i);
            FUNCT3_BGEU: taken_o = (rs1_i >= rs2_i);
            default:     illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC, single-outstanding fetch, 1-entry instruction
// buffer and a three-state branch resolver that redirects fetch.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus
);

    br_state_e       state_q;
    br_kind_e        kind_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] rs1_q, rs2_q, bpc_q, off_q;
    logic            taken_q, illegal_q;
    logic [XLEN-1:0] target_q;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            outstanding_q, outstanding_d;
    logic            discard_q, discard_d;
    logic            stale_q, stale_d;
    logic            inst_valid_q, inst_valid_d;
    logic [XLEN-1:0] inst_data_q, inst_data_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;

    logic            cmp_taken, cmp_illegal;
    logic            eval_taken, eval_illegal;
    logic [XLEN-1:0] eval_target;
    logic            redirect;
    logic            req_fire, rsp_in, rsp_take, inst_fire, issue;

    branch_compare u_cmp (
        .funct3_i  (funct3_q),
        .rs1_i     (rs1_q),
        .rs2_i     (rs2_q),
        .taken_o   (cmp_taken),
        .illegal_o (cmp_illegal)
    );

    always_comb begin
        eval_taken   = 1'b0;
        eval_illegal = 1'b0;
        eval_target  = bpc_q + off_q;
        unique case (kind_q)
            BK_BR: begin
                eval_taken   = cmp_taken;
                eval_illegal = cmp_illegal;
            end
            BK_JAL:  eval_taken = 1'b1;
            BK_JALR: begin
                eval_taken  = 1'b1;
                eval_target = (rs1_q + off_q) & ~32'h1;
            end
            default: eval_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            kind_q    <= BK_BR;
            funct3_q  <= 3'b000;
            rs1_q     <= '0;
            rs2_q     <= '0;
            bpc_q     <= '0;
            off_q     <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            target_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.br_valid) begin
                    kind_q   <= bus.br_kind;
                    funct3_q <= bus.br_funct3;
                    rs1_q    <= bus.br_rs1;
                    rs2_q    <= bus.br_rs2;
                    bpc_q    <= bus.br_pc;
                    off_q    <= bus.br_offset;
                    state_q  <= EVAL;
                end
                EVAL: begin
                    taken_q   <= eval_taken;
                    illegal_q <= eval_illegal;
                    target_q  <= eval_target;
                    state_q   <= RESOLVE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign redirect = (state_q == RESOLVE) && taken_q
                   && !misaligned(target_q);

    assign req_fire  = req_valid_q && bus.fetch_req_ready;
    assign rsp_in    = bus.fetch_rsp_valid && outstanding_q;
    assign rsp_take  = rsp_in && !discard_q && !redirect;
    assign inst_fire = inst_valid_q && bus.inst_ready;
    // No new request in a redirect cycle: pc_q still holds the old path.
    assign issue = !req_valid_q && !outstanding_q && !redirect
                && (!inst_valid_q || inst_fire);

    always_comb begin
        pc_d          = pc_q;
        req_valid_d   = req_valid_q;
        req_addr_d    = req_addr_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        stale_d       = stale_q;
        inst_valid_d  = inst_valid_q;
        inst_data_d   = inst_data_q;
        inst_pc_d     = inst_pc_q;

        if (redirect)
            pc_d = target_q;
        else if (req_fire && !stale_q)
            pc_d = pc_q + 32'd4;

        if (req_fire)
            req_valid_d = 1'b0;
        if (issue) begin
            req_valid_d = 1'b1;
            req_addr_d  = pc_q;
        end

        if (req_fire)
            outstanding_d = 1'b1;
        else if (rsp_in)
            outstanding_d = 1'b0;

        // A held wrong-path request still completes; remember to drop it.
        if (redirect && req_valid_q && !bus.fetch_req_ready)
            stale_d = 1'b1;
        else if (req_fire)
            stale_d = 1'b0;

        if (rsp_in && discard_q)
            discard_d = 1'b0;
        if (req_fire && stale_q)
            discard_d = 1'b1;
        if (redirect && ((outstanding_q && !rsp_in) || req_fire))
            discard_d = 1'b1;

        if (inst_fire)
            inst_valid_d = 1'b0;
        if (rsp_take) begin
            inst_valid_d = 1'b1;
            inst_data_d  = bus.fetch_rsp_data;
            inst_pc_d    = req_addr_q;
        end
        if (redirect)
            inst_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            req_valid_q   <= 1'b0;
            req_addr_q    <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            stale_q       <= 1'b0;
            inst_valid_q  <= 1'b0;
            inst_data_q   <= '0;
            inst_pc_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            stale_q       <= stale_d;
            inst_valid_q  <= inst_valid_d;
            inst_data_q   <= inst_data_d;
            inst_pc_q     <= inst_pc_d;
        end
    end

    assign bus.fetch_req_valid = req_valid_q;
    assign bus.fetch_addr      = req_addr_q;
    assign bus.inst_valid      = inst_valid_q;
    assign bus.inst_data       = inst_data_q;
    assign bus.inst_pc         = inst_pc_q;
    assign bus.br_ready        = (state_q == IDLE) && !rst;
    assign bus.br_done         = (state_q == RESOLVE);
    assign bus.br_link         = bpc_q + 32'd4;
    assign bus.br_misalign     = (state_q == RESOLVE) && taken_q
                              && misaligned(target_q);
    assign bus.br_illegal      = (state_q == RESOLVE) && illegal_q;
    assign bus.flush           = redirect;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch flow, branch resolve,
// redirect with in-flight fetch, and reset during evaluation.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pc_sequencer_if bus();

    pc_sequencer #(.RESET_PC(32'h100), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept();
        bus.fetch_req_ready = 1'b1;
        step();
        bus.fetch_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        bus.fetch_rsp_valid = 1'b1;
        bus.fetch_rsp_data  = data;
        step();
        bus.fetch_rsp_valid = 1'b0;
    endtask

    task automatic branch(input br_kind_e k, input logic [2:0] f3,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] pc, input logic [31:0] off);
        bus.br_valid  = 1'b1;
        bus.br_kind   = k;
        bus.br_funct3 = f3;
        bus.br_rs1    = rs1;
        bus.br_rs2    = rs2;
        bus.br_pc     = pc;
        bus.br_offset = off;
        step();
        bus.br_valid  = 1'b0;
    endtask

    initial begin
        rst                 = 1'b1;
        bus.fetch_req_ready = 1'b0;
        bus.fetch_rsp_valid = 1'b0;
        bus.fetch_rsp_data  = '0;
        bus.inst_ready      = 1'b0;
        bus.br_valid        = 1'b0;
        bus.br_kind         = BK_BR;
        bus.br_funct3       = 3'b000;
        bus.br_rs1          = '0;
        bus.br_rs2          = '0;
        bus.br_pc           = '0;
        bus.br_offset       = '0;
        step();
        step();
        check("rst_req_valid", bus.fetch_req_valid, 0);
        check("rst_br_ready", bus.br_ready, 0);
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_br_done", bus.br_done, 0);
        check("rst_flush", bus.flush, 0);

        // 1: first fetch and sequential follow-on
        rst = 1'b0;
        step();
        check("t1_req_valid", bus.fetch_req_valid, 1);
        check("t1_addr", bus.fetch_addr, 32'h100);
        check("t1_br_ready", bus.br_ready, 1);
        step();
        check("t1_hold_valid", bus.fetch_req_valid, 1);
        check("t1_hold_addr", bus.fetch_addr, 32'h100);
        accept();
        check("t1_req_clear", bus.fetch_req_valid, 0);
        respond(32'h0000_0013);
        check("t1_inst_valid", bus.inst_valid, 1);
        check("t1_inst_data", bus.inst_data, 32'h13);
        check("t1_inst_pc", bus.inst_pc, 32'h100);
        check("t1_no_issue_full", bus.fetch_req_valid, 0);
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        check("t1_inst_drained", bus.inst_valid, 0);
        check("t1_next_valid", bus.fetch_req_valid, 1);
        check("t1_next_addr", bus.fetch_addr, 32'h104);

        // 2: BEQ taken while request 0x104 is still unaccepted
        branch(BK_BR, 3'b000, 32'd5, 32'd5, 32'h200, 32'h10);
        check("t2_eval_done", bus.br_done, 0);
        check("t2_eval_ready", bus.br_ready, 0);
        step();
        check("t2_done", bus.br_done, 1);
        check("t2_flush", bus.flush, 1);
        check("t2_link", bus.br_link, 32'h204);
        check("t2_misalign", bus.br_misalign, 0);
        step();
        check("t2_done_pulse", bus.br_done, 0);
        check("t2_flush_pulse", bus.flush, 0);
        check("t2_old_req_held", bus.fetch_addr, 32'h104);
        accept();
        respond(32'hDEAD_BEEF);
        check("t2_stale_dropped", bus.inst_valid, 0);
        step();
        check("t2_tgt_valid", bus.fetch_req_valid, 1);
        check("t2_tgt_addr", bus.fetch_addr, 32'h210);
        accept();
        respond(32'h0000_0033);
        check("t2_inst_pc", bus.inst_pc, 32'h210);
        check("t2_inst_data", bus.inst_data, 32'h33);

        // 3: signed lt taken, unsigned lt not taken
        branch(BK_BR, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h20);
        step();
        check("t3_blt_flush", bus.flush, 1);
        step();
        check("t3_buf_cleared", bus.inst_valid, 0);
        check("t3_no_req_flush", bus.fetch_req_valid, 0);
        step();
        check("t3_tgt_addr", bus.fetch_addr, 32'h320);
        accept();
        respond(32'h0000_0013);
        check("t3_inst_pc", bus.inst_pc, 32'h320);
        branch(BK_BR, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h40);
        step();
        check("t3_bltu_done", bus.br_done, 1);
        check("t3_bltu_flush", bus.flush, 0);
        step();
        check("t3_buf_kept", bus.inst_pc, 32'h320);
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        check("t3_seq_valid", bus.fetch_req_valid, 1);
        check("t3_seq_addr", bus.fetch_addr, 32'h324);
        accept();
        respond(32'h0000_0013);
        check("t3_seq_inst_pc", bus.inst_pc, 32'h324);

        // 4: JALR aligned and misaligned
        branch(BK_JALR, 3'b000, 32'h1003, 32'd0, 32'h500, 32'd1);
        step();
        check("t4_jalr_flush", bus.flush, 1);
        check("t4_jalr_link", bus.br_link, 32'h504);
        check("t4_jalr_misalign", bus.br_misalign, 0);
        step();
        step();
        check("t4_jalr_addr", bus.fetch_addr, 32'h1004);
        accept();
        branch(BK_JALR, 3'b000, 32'h1001, 32'd0, 32'h600, 32'd1);
        step();
        check("t4_mis_done", bus.br_done, 1);
        check("t4_mis_misalign", bus.br_misalign, 1);
        check("t4_mis_flush", bus.flush, 0);
        check("t4_mis_link", bus.br_link, 32'h604);
        step();
        respond(32'h0000_0013);
        check("t4_mis_inst_pc", bus.inst_pc, 32'h1004);
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        check("t4_pc_unchanged", bus.fetch_addr, 32'h1008);

        // 5: JAL redirect with outstanding fetch, late response
        accept();
        branch(BK_JAL, 3'b000, 32'd0, 32'd0, 32'h700, 32'h100);
        step();
        check("t5_flush", bus.flush, 1);
        respond(32'h0BAD_0BAD);
        check("t5_rsp_dropped", bus.inst_valid, 0);
        step();
        check("t5_tgt_valid", bus.fetch_req_valid, 1);
        check("t5_tgt_addr", bus.fetch_addr, 32'h800);
        accept();
        respond(32'h0000_0055);
        check("t5_inst_pc", bus.inst_pc, 32'h800);
        check("t5_inst_data", bus.inst_data, 32'h55);

        // 6: reset in EVAL, then illegal funct3
        branch(BK_BR, 3'b000, 32'd1, 32'd1, 32'h900, 32'h8);
        rst = 1'b1;
        step();
        check("t6_rst_done", bus.br_done, 0);
        check("t6_rst_flush", bus.flush, 0);
        check("t6_rst_ready", bus.br_ready, 0);
        rst = 1'b0;
        step();
        check("t6_post_done", bus.br_done, 0);
        check("t6_post_flush", bus.flush, 0);
        check("t6_post_ready", bus.br_ready, 1);
        check("t6_post_addr", bus.fetch_addr, 32'h100);
        respond(32'h1111_1111);
        check("t6_late_rsp", bus.inst_valid, 0);
        branch(BK_BR, 3'b011, 32'd3, 32'd3, 32'h940, 32'h10);
        step();
        check("t6_ill_done", bus.br_done, 1);
        check("t6_ill_flag", bus.br_illegal, 1);
        check("t6_ill_flush", bus.flush, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
